vga_pixel_fetch: RTL and testbench

// - Display-side counterpart of the pixel memory controller: generates 640x480@60 VGA timing,

---
 rtl/vga_pixel_fetch.sv | 142 ++++++++++++++
 tb/tb_vga_pixel_fetch.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_fetch.sv
// VGA timing generator and pixel fetcher: issues frame-buffer / alphabet-window addresses,
// delays sync and blanking to match the memory read latency, and drives registered RGB.
module vga_pixel_fetch #(
   parameter int CLK_DIV  = 4,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int MEM_LAT  = 1,
   parameter int WIN_X0   = 80,
   parameter int WIN_Y0   = 40,
   parameter int WIN_W    = 160,
   parameter int WIN_H    = 160
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [11:0] pixel,
   output logic [16:0] pixel_addr,
   output logic        flag_alphabet,
   output logic        hsync,
   output logic        vsync,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        frame_start
);
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW       = $clog2(H_TOTAL);
   localparam int VW       = $clog2(V_TOTAL);
   localparam int DW       = $clog2(CLK_DIV);
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int SRC_W    = 32'sd320;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] DIV_PRE  = DW'(CLK_DIV - 2);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

   logic [DW-1:0]    div_q, div_d;
   logic [HW-1:0]    h_q, h_d;
   logic [VW-1:0]    v_q, v_d;
   logic             tick_s, pre_tick_s;
   int               h_s, v_s, x_s, y_s;
   logic             active_s, win_s, hs_s, vs_s;
   logic [16:0]      addr_d, addr_q;
   logic [MEM_LAT:0] win_pipe_q, act_pipe_q, hs_pipe_q, vs_pipe_q;
   logic             hsync_q, vsync_q, frame_q;
   logic [11:0]      rgb_q;

   assign tick_s     = (div_q == DIV_LAST);
   assign pre_tick_s = (div_q == DIV_PRE);

   // Pixel-tick divider and raster counters, next state
   always_comb begin
      div_d = tick_s ? '0 : div_q + DW'(1);
      h_d   = h_q;
      v_d   = v_q;
      if (tick_s) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
         end else begin
            h_d = h_q + HW'(1);
         end
      end else begin
         h_d = h_q;
         v_d = v_q;
      end
   end

   // Issue-stage decode: each source pixel covers a 2x2 block of the 640x480 raster
   always_comb begin
      h_s      = int'(h_q);
      v_s      = int'(v_q);
      x_s      = int'(h_q[HW-1:1]);
      y_s      = int'(v_q[VW-1:1]);
      active_s = (h_s < H_ACTIVE) && (v_s < V_ACTIVE);
      win_s    = active_s && (x_s >= WIN_X0) && (x_s < WIN_X0 + WIN_W)
                          && (y_s >= WIN_Y0) && (y_s < WIN_Y0 + WIN_H);
      hs_s     = !((h_s >= HS_START) && (h_s < HS_END));
      vs_s     = !((v_s >= VS_START) && (v_s < VS_END));
      if (win_s) begin
         addr_d = 17'((y_s - WIN_Y0) * WIN_W + (x_s - WIN_X0));
      end else if (active_s) begin
         addr_d = 17'(y_s * SRC_W + x_s);
      end else begin
         addr_d = 17'd0;
      end
   end

   // Counters; frame_start is set one clk early so it is high exactly on the h=v=0 tick cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
         frame_q <= 1'b0;
      end else begin
         div_q   <= div_d;
         h_q     <= h_d;
         v_q     <= v_d;
         frame_q <= pre_tick_s && (h_q == '0) && (v_q == '0);
      end
   end

   // Address issue, latency-matching delay pipes and blanked RGB, all on pixel ticks
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q     <= 17'd0;
         win_pipe_q <= '0;
         act_pipe_q <= '0;
         hs_pipe_q  <= '1;
         vs_pipe_q  <= '1;
         hsync_q    <= 1'b1;
         vsync_q    <= 1'b1;
         rgb_q      <= 12'h000;
      end else if (tick_s) begin
         addr_q     <= addr_d;
         win_pipe_q <= {win_pipe_q[MEM_LAT-1:0], win_s};
         act_pipe_q <= {act_pipe_q[MEM_LAT-1:0], active_s};
         hs_pipe_q  <= {hs_pipe_q[MEM_LAT-1:0], hs_s};
         vs_pipe_q  <= {vs_pipe_q[MEM_LAT-1:0], vs_s};
         hsync_q    <= hs_pipe_q[MEM_LAT];
         vsync_q    <= vs_pipe_q[MEM_LAT];
         rgb_q      <= act_pipe_q[MEM_LAT] ? pixel : 12'h000;
      end
   end

   assign pixel_addr             = addr_q;
   assign flag_alphabet          = win_pipe_q[MEM_LAT];
   assign hsync                  = hsync_q;
   assign vsync                  = vsync_q;
   assign {vga_r, vga_g, vga_b}  = rgb_q;
   assign frame_start            = frame_q;
endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Bench: one full-size instance plus three reduced-raster instances (MEM_LAT 1..3) compared
// every clk against an arithmetic raster model, with a latency-configurable memory model.
module tb_vga_pixel_fetch;
   localparam int ND   = 4;
   localparam int D    = 4;
   localparam int NREC = 4400;
   localparam int HT  [ND] = '{800, 80, 80, 80};
   localparam int VT  [ND] = '{525, 55, 55, 55};
   localparam int HA  [ND] = '{640, 64, 64, 64};
   localparam int VA  [ND] = '{480, 48, 48, 48};
   localparam int HSS [ND] = '{656, 68, 68, 68};
   localparam int HSW [ND] = '{96, 8, 8, 8};
   localparam int VSS [ND] = '{490, 50, 50, 50};
   localparam int VSW [ND] = '{2, 2, 2, 2};
   localparam int X0  [ND] = '{80, 8, 8, 8};
   localparam int Y0  [ND] = '{40, 4, 4, 4};
   localparam int WW  [ND] = '{160, 16, 16, 16};
   localparam int WH  [ND] = '{160, 16, 16, 16};
   localparam int LAT [ND] = '{1, 1, 2, 3};

   typedef struct packed {logic [16:0] addr; logic win; logic act; logic hs; logic vs;} iss_t;
   typedef struct packed {logic [16:0] addr; logic flag; logic hs; logic vs; logic [11:0] rgb; logic fs;} out_t;
   typedef struct {int d; int h; int v; logic [16:0] addr; logic flag;} vec_t;

   logic        clk, rst_n;
   logic [11:0] key;
   logic [11:0] pix_w  [ND];
   logic [16:0] addr_w [ND];
   logic        flag_w [ND], hs_w [ND], vs_w [ND], fs_w [ND];
   logic [3:0]  r_w [ND], g_w [ND], b_w [ND];
   logic [16:0] hist [ND][4];
   int          e_cnt;
   int          errors, checks;
   logic        record_en;
   logic [16:0] rec_addr [ND][NREC];
   logic        rec_flag [ND][NREC], rec_hs [ND][NREC], rec_vs [ND][NREC];
   vec_t        tbl [19];

   vga_pixel_fetch #(.MEM_LAT(1)) u_full (
      .clk(clk), .rst_n(rst_n), .pixel(pix_w[0]), .pixel_addr(addr_w[0]), .flag_alphabet(flag_w[0]),
      .hsync(hs_w[0]), .vsync(vs_w[0]), .vga_r(r_w[0]), .vga_g(g_w[0]), .vga_b(b_w[0]), .frame_start(fs_w[0]));

   vga_pixel_fetch #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .WIN_X0(8), .WIN_Y0(4), .WIN_W(16), .WIN_H(16), .MEM_LAT(1)) u_s1 (
      .clk(clk), .rst_n(rst_n), .pixel(pix_w[1]), .pixel_addr(addr_w[1]), .flag_alphabet(flag_w[1]),
      .hsync(hs_w[1]), .vsync(vs_w[1]), .vga_r(r_w[1]), .vga_g(g_w[1]), .vga_b(b_w[1]), .frame_start(fs_w[1]));

   vga_pixel_fetch #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .WIN_X0(8), .WIN_Y0(4), .WIN_W(16), .WIN_H(16), .MEM_LAT(2)) u_s2 (
      .clk(clk), .rst_n(rst_n), .pixel(pix_w[2]), .pixel_addr(addr_w[2]), .flag_alphabet(flag_w[2]),
      .hsync(hs_w[2]), .vsync(vs_w[2]), .vga_r(r_w[2]), .vga_g(g_w[2]), .vga_b(b_w[2]), .frame_start(fs_w[2]));

   vga_pixel_fetch #(.H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4), .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
      .WIN_X0(8), .WIN_Y0(4), .WIN_W(16), .WIN_H(16), .MEM_LAT(3)) u_s3 (
      .clk(clk), .rst_n(rst_n), .pixel(pix_w[3]), .pixel_addr(addr_w[3]), .flag_alphabet(flag_w[3]),
      .hsync(hs_w[3]), .vsync(vs_w[3]), .vga_r(r_w[3]), .vga_g(g_w[3]), .vga_b(b_w[3]), .frame_start(fs_w[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Clk count since reset release, plus memory address history shifted on every pixel tick
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_cnt <= 0;
         for (int d = 0; d < ND; d++)
            for (int k = 0; k < 4; k++) hist[d][k] <= 17'd0;
      end else begin
         if (e_cnt % D == D - 1) begin
            for (int d = 0; d < ND; d++) begin
               hist[d][0] <= addr_w[d];
               for (int k = 1; k < 4; k++) hist[d][k] <= hist[d][k-1];
            end
         end
         e_cnt <= e_cnt + 1;
      end
   end

   // Memory data: address bits, scrambled by a random key when the alphabet ROM is selected
   always_comb begin
      for (int d = 0; d < ND; d++)
         pix_w[d] = flag_w[d] ? (hist[d][LAT[d]-1][11:0] ^ key) : hist[d][LAT[d]-1][11:0];
   end

   function automatic iss_t issue(int d, int t);
      iss_t s;
      int h, v, x, y;
      h = t % HT[d];
      v = (t / HT[d]) % VT[d];
      x = h / 2;
      y = v / 2;
      s.act = (h < HA[d]) && (v < VA[d]);
      s.win = s.act && (x >= X0[d]) && (x < X0[d] + WW[d]) && (y >= Y0[d]) && (y < Y0[d] + WH[d]);
      s.hs  = !((h >= HSS[d]) && (h < HSS[d] + HSW[d]));
      s.vs  = !((v >= VSS[d]) && (v < VSS[d] + VSW[d]));
      if (s.win)      s.addr = 17'((y - Y0[d]) * WW[d] + (x - X0[d]));
      else if (s.act) s.addr = 17'(y * 320 + x);
      else            s.addr = 17'd0;
      return s;
   endfunction

   // Expected outputs after e clks since release: n ticks done, last tick index n-1
   function automatic out_t expect_out(int d, int e, logic [11:0] k);
      out_t o;
      iss_t s;
      int n, t;
      n = e / D;
      o = '{addr: 17'd0, flag: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 12'h000, fs: 1'b0};
      o.fs = (e % D == D - 1) && (n % (HT[d] * VT[d]) == 0);
      if (n >= 1) begin
         t = n - 1;
         o.addr = issue(d, t).addr;
         if (t >= LAT[d]) o.flag = issue(d, t - LAT[d]).win;
         if (t >= LAT[d] + 1) begin
            s    = issue(d, t - LAT[d] - 1);
            o.hs = s.hs;
            o.vs = s.vs;
            if (s.act) o.rgb = s.win ? (s.addr[11:0] ^ k) : s.addr[11:0];
         end
      end
      return o;
   endfunction

   task automatic check_all();
      out_t got, exp;
      int n;
      if (errors >= 40) return;
      n = e_cnt / D;
      for (int d = 0; d < ND; d++) begin
         got = {addr_w[d], flag_w[d], hs_w[d], vs_w[d], r_w[d], g_w[d], b_w[d], fs_w[d]};
         exp = expect_out(d, e_cnt, key);
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL model dut%0d clk=%0d got addr=%0d flag=%b hs=%b vs=%b rgb=%h fs=%b, expected addr=%0d flag=%b hs=%b vs=%b rgb=%h fs=%b",
                     d, e_cnt, got.addr, got.flag, got.hs, got.vs, got.rgb, got.fs,
                     exp.addr, exp.flag, exp.hs, exp.vs, exp.rgb, exp.fs);
         end
         if (record_en && n >= 1 && n - 1 < NREC) begin
            rec_addr[d][n-1] = addr_w[d];
            rec_flag[d][n-1] = flag_w[d];
            rec_hs[d][n-1]   = hs_w[d];
            rec_vs[d][n-1]   = vs_w[d];
         end
      end
   endtask

   task automatic cmp(string name, int got, int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic run_clks(int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check_all();
      end
   endtask

   // Release reset and time the first frame_start, which must land on the first tick (3rd clk)
   task automatic release_and_check_first_fs(string name);
      int first;
      first = 0;
      rst_n = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         check_all();
         if (fs_w[1] && first == 0) first = k;
      end
      cmp(name, first, D - 1);
   endtask

   initial begin
      errors    = 0;
      checks    = 0;
      record_en = 1'b1;
      key       = 12'($urandom);
      rst_n     = 1'b0;
      tbl[0]  = '{0, 0, 0, 17'd0, 1'b0};
      tbl[1]  = '{0, 639, 0, 17'd319, 1'b0};
      tbl[2]  = '{0, 640, 0, 17'd0, 1'b0};
      tbl[3]  = '{0, 1, 1, 17'd0, 1'b0};
      tbl[4]  = '{0, 2, 2, 17'd321, 1'b0};
      tbl[5]  = '{1, 0, 0, 17'd0, 1'b0};
      tbl[6]  = '{1, 16, 8, 17'd0, 1'b1};
      tbl[7]  = '{1, 15, 8, 17'd1287, 1'b0};
      tbl[8]  = '{1, 16, 7, 17'd968, 1'b0};
      tbl[9]  = '{1, 30, 20, 17'd103, 1'b1};
      tbl[10] = '{1, 47, 39, 17'd255, 1'b1};
      tbl[11] = '{1, 48, 39, 17'd6104, 1'b0};
      tbl[12] = '{1, 47, 40, 17'd6423, 1'b0};
      tbl[13] = '{1, 63, 47, 17'd7391, 1'b0};
      tbl[14] = '{1, 64, 0, 17'd0, 1'b0};
      tbl[15] = '{1, 63, 48, 17'd0, 1'b0};
      tbl[16] = '{1, 0, 54, 17'd0, 1'b0};
      tbl[17] = '{2, 16, 8, 17'd0, 1'b1};
      tbl[18] = '{3, 16, 8, 17'd0, 1'b1};

      run_clks(3);
      @(negedge clk);
      release_and_check_first_fs("first_frame_start_cold");
      run_clks(4500 * D - 20);

      for (int i = 0; i < 19; i++) begin
         int t;
         t = tbl[i].v * HT[tbl[i].d] + tbl[i].h;
         cmp($sformatf("addr_vec%0d", i), int'(rec_addr[tbl[i].d][t]), int'(tbl[i].addr));
         cmp($sformatf("flag_vec%0d", i), int'(rec_flag[tbl[i].d][t + LAT[tbl[i].d]]), int'(tbl[i].flag));
      end
      cmp("hsync_before_fall", int'(rec_hs[0][657]), 1);
      cmp("hsync_fall",        int'(rec_hs[0][658]), 0);
      cmp("hsync_last_low",    int'(rec_hs[0][753]), 0);
      cmp("hsync_rise",        int'(rec_hs[0][754]), 1);
      cmp("vsync_before_fall", int'(rec_vs[3][4003]), 1);
      cmp("vsync_fall",        int'(rec_vs[3][4004]), 0);
      cmp("vsync_last_low",    int'(rec_vs[3][4163]), 0);
      cmp("vsync_rise",        int'(rec_vs[3][4164]), 1);

      record_en = 1'b0;
      run_clks($urandom_range(300, 5));
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_all();
      run_clks(3);
      release_and_check_first_fs("first_frame_start_warm");
      run_clks(4500 * D - 20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
